id_ex_stage: RTL

- Decode stage plus ID/EX pipeline register of the 5-stage RV32I pipeline.
- Takes fetched instructions from IF and drives the read addresses of the dual-port register file.
- Captures the operands the register file returns, decodes control signals and the immediate, and registers everything for EX.
- Detects load-use hazards, inserts bubbles, and honours EX back-pressure and branch flush.

---
 rtl/riscv_pkg.sv | 51 +++++
 rtl/imm_gen.sv | 27 ++
 rtl/id_ex_stage.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: opcodes, ALU operation codes, immediate formats and decoded control bundle.
package riscv_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    // M-extension codes are 16 + funct3 so they can be formed directly from the encoding
    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_PASS_B = 5'd10,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alu_op_e;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_R} imm_type_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    alu_src_imm;
        logic    alu_src_pc;
        logic    mem_read;
        logic    mem_write;
        logic    reg_write;
        logic    branch;
        logic    jump;
        logic    illegal;
    } ctrl_t;

endpackage

// File: rtl/imm_gen.sv
// imm_gen: builds the sign-extended immediate for each RV32I instruction format.
module imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  imm_type_e       imm_type,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        case (imm_type)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = 32'b0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I decode plus ID/EX register with load-use bubble, back-pressure and flush.
// Define DECODE_MULDIV_EN to decode the M-extension OP encodings instead of flagging them illegal.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_pc,
    input  logic [31:0]     i_instr,
    output logic [4:0]      o_rs1_addr,
    output logic [4:0]      o_rs2_addr,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic            i_flush,
    input  logic            i_ex_ready,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_rs1_val,
    output logic [XLEN-1:0] o_rs2_val,
    output logic [XLEN-1:0] o_imm,
    output logic [4:0]      o_rd_addr,
    output logic [2:0]      o_funct3,
    output logic [4:0]      o_alu_op,
    output logic            o_alu_src_imm,
    output logic            o_alu_src_pc,
    output logic            o_mem_read,
    output logic            o_mem_write,
    output logic            o_reg_write,
    output logic            o_branch,
    output logic            o_jump,
    output logic            o_illegal
);

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rd;
    logic            uses_rs1, uses_rs2, hazard, advance;
    alu_op_e         arith_op;
    imm_type_e       imm_type;
    ctrl_t           ctrl, ctrl_q;
    logic [XLEN-1:0] imm;

    assign opcode     = i_instr[6:0];
    assign rd         = i_instr[11:7];
    assign f3         = i_instr[14:12];
    assign f7         = i_instr[31:25];
    assign o_rs1_addr = i_instr[19:15];
    assign o_rs2_addr = i_instr[24:20];

    always_comb begin
        case (f3)
            3'b000:  arith_op = (opcode == OP && f7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = f7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    end

    always_comb begin
        ctrl     = '0;
        ctrl.alu_op = ALU_ADD;
        imm_type = IMM_R;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            LUI: begin
                imm_type = IMM_U;
                ctrl.alu_op = ALU_PASS_B;
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            AUIPC, JAL: begin
                imm_type = (opcode == JAL) ? IMM_J : IMM_U;
                ctrl.alu_src_imm = 1'b1;
                ctrl.alu_src_pc = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.jump = (opcode == JAL);
            end
            JALR: begin
                imm_type = IMM_I;
                uses_rs1 = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.jump = 1'b1;
                ctrl.illegal = (f3 != 3'b000);
            end
            BRANCH: begin
                imm_type = IMM_B;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                ctrl.alu_op = ALU_SUB;
                ctrl.branch = 1'b1;
                ctrl.illegal = (f3[2:1] == 2'b01);
            end
            LOAD: begin
                imm_type = IMM_I;
                uses_rs1 = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.mem_read = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            STORE: begin
                imm_type = IMM_S;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.illegal = f3[2] || (f3[1:0] == 2'b11);
            end
            OP_IMM: begin
                imm_type = IMM_I;
                uses_rs1 = 1'b1;
                ctrl.alu_op = arith_op;
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.illegal = (f3 == 3'b001 && f7 != 7'b0) ||
                               (f3 == 3'b101 && f7 != 7'b0 && f7 != 7'b0100000);
            end
            OP: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                ctrl.alu_op = arith_op;
                ctrl.reg_write = 1'b1;
                ctrl.illegal = !(f7 == 7'b0 ||
                                 (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
`ifdef DECODE_MULDIV_EN
                if (f7 == 7'b0000001) begin
                    ctrl.alu_op = alu_op_e'({2'b10, f3});
                    ctrl.illegal = 1'b0;
                end
`endif
            end
            default: ctrl.illegal = 1'b1;
        endcase
        // Illegal instructions travel down the pipe but must have no side effects
        if (ctrl.illegal) begin
            ctrl.reg_write = 1'b0;
            ctrl.mem_read  = 1'b0;
            ctrl.mem_write = 1'b0;
            ctrl.branch    = 1'b0;
            ctrl.jump      = 1'b0;
        end
        if (rd == 5'd0) ctrl.reg_write = 1'b0;
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr    (i_instr),
        .imm_type (imm_type),
        .imm      (imm)
    );

    assign advance = !o_valid || i_ex_ready;
    assign hazard  = o_valid && ctrl_q.mem_read && o_rd_addr != 5'd0 && i_valid &&
                     ((o_rd_addr == o_rs1_addr && uses_rs1) || (o_rd_addr == o_rs2_addr && uses_rs2));
    // A flushed instruction is consumed (and discarded) so IF can move to the new target
    assign o_ready = i_flush || (advance && !hazard);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid   <= 1'b0;
            o_pc      <= RESET_PC;
            o_rs1_val <= '0;
            o_rs2_val <= '0;
            o_imm     <= '0;
            o_rd_addr <= '0;
            o_funct3  <= '0;
            ctrl_q    <= '0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (advance) begin
            if (hazard) begin
                o_valid <= 1'b0;
                ctrl_q  <= '0;
            end else if (i_valid) begin
                o_valid   <= 1'b1;
                o_pc      <= i_pc;
                o_rs1_val <= i_rs1_data;
                o_rs2_val <= i_rs2_data;
                o_imm     <= imm;
                o_rd_addr <= rd;
                o_funct3  <= f3;
                ctrl_q    <= ctrl;
            end else begin
                o_valid <= 1'b0;
            end
        end
    end

    assign o_alu_op      = ctrl_q.alu_op;
    assign o_alu_src_imm = ctrl_q.alu_src_imm;
    assign o_alu_src_pc  = ctrl_q.alu_src_pc;
    assign o_mem_read    = ctrl_q.mem_read;
    assign o_mem_write   = ctrl_q.mem_write;
    assign o_reg_write   = ctrl_q.reg_write;
    assign o_branch      = ctrl_q.branch;
    assign o_jump        = ctrl_q.jump;
    assign o_illegal     = ctrl_q.illegal;

endmodule
